irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt controller answering the control unit's interrupt handshake. It latches external interrupt lines into pending bits and applies a mask. It raises an interrupt request toward the control unit, and on acknowledge it selects the highest-priority source and presents its 16-bit vector number. It blocks further requests until the ISR signals end-of-interrupt. It drives the control unit's I_irq_active input and consumes its O_irq_ack output.

## Interface
- NUM_IRQ, 8, number of interrupt sources (1..16); line 0 has highest priority
- VECTOR_BASE, 16'h0010, vector number of line 0; line n maps to VECTOR_BASE + n
- I_clk  in  1  clock
- I_reset  in  1  synchronous, active-high reset
- I_irq_lines  in  NUM_IRQ  external interrupt sources, synchronous to I_clk
- I_irq_ack  in  1  one-cycle acknowledge pulse from the control unit
- I_eoi  in  1  one-cycle end-of-interrupt pulse from the ISR path
- I_mask_we  in  1  mask write strobe
- I_mask_data  in  NUM_IRQ  new mask value (1 = masked)
- O_irq_active  out  1  request to the control unit
- O_irq_number  out  16  vector of the acknowledged source
- O_irq_number_valid  out  1  one-cycle strobe when O_irq_number updates
- O_mask  out  NUM_IRQ  current mask
- O_pending  out  NUM_IRQ  current pending bits
- O_in_service  out  1  an ISR is in progress

## Operation
- State machine with three states: IDLE, VECTOR, SERVICE.
- Pending (edge mode): the previous line value is registered. On each 0->1 edge of line n, pending[n] is set. The bit stays set until that source is acknowledged.
- Eligible = pending & ~mask. O_irq_active = (state == IDLE) && |eligible, registered.
- IDLE + I_irq_ack + O_irq_active: the lowest eligible index k is chosen. pending[k] is cleared, O_irq_number <= VECTOR_BASE + k (16-bit wrap), and the state goes to VECTOR.
- I_irq_ack while O_irq_active == 0, or in a non-IDLE state: ignored, no state change.
- VECTOR: O_irq_number_valid = 1 for this cycle only. The state then goes to SERVICE.
- SERVICE: O_in_service = 1 and O_irq_active = 0, so requests do not nest. Pending bits continue to accumulate. I_eoi moves the state to IDLE. I_eoi in IDLE or VECTOR is ignored.
- Same-cycle edge on line k and ack clearing k: the set wins and pending[k] stays 1.
- I_mask_we takes effect on the next cycle in any state. Masking a bit does not clear its pending bit. An in-service source is unaffected by masking.
- Reset values: state IDLE, pending 0, previous-line register 0, mask all ones, O_irq_number 0, O_irq_number_valid 0, O_irq_active 0, O_in_service 0. A reset during VECTOR or SERVICE abandons the ISR with no EOI required.

## Timing
- Line edge at cycle t: pending is set at t+1 and O_irq_active is high at t+2.
- Ack sampled at cycle a: O_irq_active drops at a+1, and O_irq_number plus the valid strobe are present at a+1. O_irq_number holds until the next acknowledge. This fits the control unit's two-cycle number-fetch window.
- EOI sampled at e: state is IDLE at e+1. If any source is eligible, O_irq_active is high at e+2.
- Mask write at w: new O_mask at w+1, and O_irq_active reflects it at w+2.

## Configuration
- IRQ_LEVEL_TRIG_EN defined: sources are level-sensitive. pending[n] = registered I_irq_lines[n]. Acknowledge does not clear the bit, and the source must deassert before EOI or it re-requests after EOI. The edge detector is removed.
- IRQ_LEVEL_TRIG_EN undefined (default): rising-edge latched behaviour as described above.

## Test plan
- Reset, write mask 8'h00, pulse line 3 -> O_irq_active high 2 cycles later. Ack -> O_irq_number = 16'h0013 with a one-cycle valid strobe, O_in_service = 1.
- Lines 5 and 2 rise in the same cycle -> first ack returns 16'h0012. EOI, second ack returns 16'h0015. Pending is then 0.
- Mask = 8'h04, pulse line 2 -> no request and pending[2] = 1. Write mask 8'h00 -> request appears 2 cycles later. Ack returns 16'h0012.
- In SERVICE, pulse line 0 -> O_irq_active stays 0. Ack is ignored and O_irq_number is unchanged. After EOI, request appears and ack returns 16'h0010.
- Line 1 edge coincides with the ack selecting line 1 -> pending[1] stays 1, and after EOI a second request returns 16'h0011.
- Assert I_reset in SERVICE -> all outputs return to reset values next cycle, and mask reads 8'hFF.

Source files
------------

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Brief    : Interrupt controller that latches, masks and prioritises sources
//            and hands the winning vector to the control unit. Define
//            IRQ_LEVEL_TRIG_EN for level-sensitive sources.
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
  parameter int          NUM_IRQ     = 8,
  parameter logic [15:0] VECTOR_BASE = 16'h0010
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic [NUM_IRQ-1:0] I_irq_lines,
  input  logic               I_irq_ack,
  input  logic               I_eoi,
  input  logic               I_mask_we,
  input  logic [NUM_IRQ-1:0] I_mask_data,
  output logic               O_irq_active,
  output logic [15:0]        O_irq_number,
  output logic               O_irq_number_valid,
  output logic [NUM_IRQ-1:0] O_mask,
  output logic [NUM_IRQ-1:0] O_pending,
  output logic               O_in_service
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_VECTOR  = 2'd1;
  localparam logic [1:0] c_SERVICE = 2'd2;
  localparam int         c_IDX_W   = 5;

  logic [1:0]         r_state;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [15:0]        r_irq_number;
  logic               r_irq_active;

  logic [NUM_IRQ-1:0] w_eligible;
  logic [c_IDX_W-1:0] w_sel_idx;
  logic               w_any;
  logic               w_take;

  assign w_eligible = r_pending & ~r_mask;
  assign w_any      = |w_eligible;

  // Scan from the top down so the lowest eligible index is the last written.
  always_comb begin
    w_sel_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_sel_idx = c_IDX_W'(i);
    end
  end

  // An ack is honoured only while a request is visibly raised and a source
  // is still eligible (a late mask write may have withdrawn it).
  assign w_take = (r_state == c_IDLE) && I_irq_ack && r_irq_active && w_any;

`ifdef IRQ_LEVEL_TRIG_EN
  always_ff @(posedge I_clk) begin
    if (I_reset) r_pending <= '0;
    else         r_pending <= I_irq_lines;
  end
`else
  logic [NUM_IRQ-1:0] r_prev_lines;
  logic [NUM_IRQ-1:0] w_clear;

  assign w_clear = w_take ? (NUM_IRQ'(1) << w_sel_idx) : '0;

  // A fresh edge on the acknowledged line is OR-ed in after the clear, so it wins.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_prev_lines <= '0;
      r_pending    <= '0;
    end else begin
      r_prev_lines <= I_irq_lines;
      r_pending    <= (r_pending & ~w_clear) | (I_irq_lines & ~r_prev_lines);
    end
  end
`endif

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_state      <= c_IDLE;
      r_mask       <= '1;
      r_irq_number <= '0;
      r_irq_active <= 1'b0;
    end else begin
      r_irq_active <= !w_take && (r_state == c_IDLE) && w_any;
      if (I_mask_we) r_mask <= I_mask_data;
      case (r_state)
        c_IDLE: begin
          if (w_take) begin
            r_state      <= c_VECTOR;
            r_irq_number <= VECTOR_BASE + 16'(w_sel_idx);
          end
        end
        c_VECTOR:  r_state <= c_SERVICE;
        c_SERVICE: if (I_eoi) r_state <= c_IDLE;
        default:   r_state <= c_IDLE;
      endcase
    end
  end

  assign O_irq_active       = r_irq_active;
  assign O_irq_number       = r_irq_number;
  assign O_irq_number_valid = (r_state == c_VECTOR);
  assign O_in_service       = (r_state == c_SERVICE);
  assign O_mask             = r_mask;
  assign O_pending          = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Brief    : Self-checking bench for irq_ctrl: directed scenarios with literal
//            expectations plus randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

  localparam int          c_N    = 8;
  localparam logic [15:0] c_BASE = 16'h0010;

  logic           clk = 1'b0;
  logic           rst;
  logic [c_N-1:0] lines;
  logic           ack, eoi, mask_we;
  logic [c_N-1:0] mask_data;
  logic           o_active, o_valid, o_in_service;
  logic [15:0]    o_number;
  logic [c_N-1:0] o_mask, o_pending;

  int n_checks = 0;
  int n_errors = 0;

  irq_ctrl #(.NUM_IRQ(c_N), .VECTOR_BASE(c_BASE)) u_dut (
    .I_clk              (clk),
    .I_reset            (rst),
    .I_irq_lines        (lines),
    .I_irq_ack          (ack),
    .I_eoi              (eoi),
    .I_mask_we          (mask_we),
    .I_mask_data        (mask_data),
    .O_irq_active       (o_active),
    .O_irq_number       (o_number),
    .O_irq_number_valid (o_valid),
    .O_mask             (o_mask),
    .O_pending          (o_pending),
    .O_in_service       (o_in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = waiting, 1 = vector handed out, 2 = ISR running.
  bit             m_ok = 0;
  int             m_phase;
  bit [c_N-1:0]   m_pending, m_prev, m_mask;
  bit [15:0]      m_number;
  bit             m_active;

  task automatic model_step();
    int           k;
    bit           take;
    bit [c_N-1:0] np;
    if (rst) begin
      m_phase = 0; m_pending = '0; m_prev = '0; m_mask = '1;
      m_number = 16'h0; m_active = 0; m_ok = 1;
      return;
    end
    k = -1;
    for (int n = 0; n < c_N; n++)
      if (k < 0 && m_pending[n] && !m_mask[n]) k = n;
    take = (m_phase == 0) && ack && m_active && (k >= 0);
`ifdef IRQ_LEVEL_TRIG_EN
    np = lines;
`else
    for (int n = 0; n < c_N; n++)
      np[n] = (m_pending[n] && !(take && n == k)) || (lines[n] && !m_prev[n]);
`endif
    m_active = !take && (m_phase == 0) && (k >= 0);
    if (take) m_number = 16'(int'(c_BASE) + k);
    if (take)                        m_phase = 1;
    else if (m_phase == 1)           m_phase = 2;
    else if (m_phase == 2 && eoi)    m_phase = 0;
    if (mask_we) m_mask = mask_data;
    m_prev    = lines;
    m_pending = np;
  endtask

  // Compare against the model every cycle, then advance it with the inputs
  // that the coming rising edge will sample.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("active",     32'(o_active),     32'(m_active));
      chk("number",     32'(o_number),     32'(m_number));
      chk("valid",      32'(o_valid),      32'(m_phase == 1));
      chk("in_service", 32'(o_in_service), 32'(m_phase == 2));
      chk("mask",       32'(o_mask),       32'(m_mask));
      chk("pending",    32'(o_pending),    32'(m_pending));
    end
    model_step();
  end

  task automatic cyc(input logic [c_N-1:0] l, input logic a = 0, input logic e = 0,
                     input logic we = 0, input logic [c_N-1:0] md = '0, input logic r = 0);
    lines = l; ack = a; eoi = e; mask_we = we; mask_data = md; rst = r;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; lines = '0; ack = 0; eoi = 0; mask_we = 0; mask_data = '0;
    @(posedge clk); #1;
    cyc('0, 0, 0, 0, '0, 1);
    chk("rst_mask", 32'(o_mask), 32'hFF);
    chk("rst_active", 32'(o_active), 0);
    chk("rst_number", 32'(o_number), 0);
`ifndef IRQ_LEVEL_TRIG_EN
    // Line 3 pulse -> request two cycles later -> vector 0x13.
    cyc('0, 0, 0, 1, 8'h00);
    cyc(8'h08);  chk("t1_pend", 32'(o_pending), 32'h08); chk("t1_act0", 32'(o_active), 0);
    cyc(8'h00);  chk("t1_act", 32'(o_active), 1);
    cyc(8'h00, 1); chk("t1_num", 32'(o_number), 32'h13); chk("t1_vld", 32'(o_valid), 1);
    chk("t1_actdrop", 32'(o_active), 0);
    cyc(8'h00);  chk("t1_isr", 32'(o_in_service), 1); chk("t1_vld0", 32'(o_valid), 0);
    cyc(8'h00, 0, 1); cyc(8'h00);
    // Lines 5 and 2 together: 2 wins, then 5.
    cyc(8'h24); cyc(8'h00);
    cyc(8'h00, 1); chk("t2_num_a", 32'(o_number), 32'h12);
    cyc(8'h00); cyc(8'h00, 0, 1); cyc(8'h00);
    chk("t2_act", 32'(o_active), 1);
    cyc(8'h00, 1); chk("t2_num_b", 32'(o_number), 32'h15); chk("t2_pend", 32'(o_pending), 0);
    cyc(8'h00); cyc(8'h00, 0, 1); cyc(8'h00);
    // Masked source stays pending until unmasked.
    cyc('0, 0, 0, 1, 8'h04);
    cyc(8'h04); cyc(8'h00);
    chk("t3_act0", 32'(o_active), 0); chk("t3_pend", 32'(o_pending), 32'h04);
    cyc('0, 0, 0, 1, 8'h00);
    chk("t3_act0b", 32'(o_active), 0);
    cyc(8'h00); chk("t3_act", 32'(o_active), 1);
    cyc(8'h00, 1); chk("t3_num", 32'(o_number), 32'h12);
    cyc(8'h00);
    // No nesting during service; stray ack ignored.
    cyc(8'h01); cyc(8'h00);
    chk("t4_act0", 32'(o_active), 0); chk("t4_pend", 32'(o_pending), 32'h01);
    cyc(8'h00, 1); chk("t4_num_hold", 32'(o_number), 32'h12); chk("t4_isr", 32'(o_in_service), 1);
    cyc(8'h00, 0, 1); cyc(8'h00); chk("t4_act", 32'(o_active), 1);
    cyc(8'h00, 1); chk("t4_num", 32'(o_number), 32'h10);
    cyc(8'h00); cyc(8'h00, 0, 1); cyc(8'h00);
    // Edge on line 1 in the same cycle as the ack that selects it.
    cyc(8'h02); cyc(8'h00);
    cyc(8'h02, 1); chk("t5_num", 32'(o_number), 32'h11); chk("t5_pend", 32'(o_pending), 32'h02);
    cyc(8'h00); cyc(8'h00, 0, 1); cyc(8'h00);
    chk("t5_act", 32'(o_active), 1);
    cyc(8'h00, 1); chk("t5_num2", 32'(o_number), 32'h11); chk("t5_vld", 32'(o_valid), 1);
    cyc(8'h10); chk("t6_isr", 32'(o_in_service), 1);
    // Reset while in service.
    cyc(8'h00, 0, 0, 0, '0, 1);
    chk("t6_mask", 32'(o_mask), 32'hFF); chk("t6_pend", 32'(o_pending), 0);
    chk("t6_isr0", 32'(o_in_service), 0); chk("t6_num", 32'(o_number), 0);
    chk("t6_act", 32'(o_active), 0); chk("t6_vld", 32'(o_valid), 0);
`endif
    // Randomized traffic, checked by the model every cycle.
    begin
      logic [c_N-1:0] l;
      l = '0;
      for (int i = 0; i < 3000; i++) begin
        l = l ^ c_N'($urandom & $urandom & $urandom);
        cyc(l,
            ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 19) == 0),
            c_N'($urandom & $urandom),
            ($urandom_range(0, 199) == 0));
      end
    end
    cyc('0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
